// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and FSM state type for the RAM responder.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WRESP = 2'd2,
    READ  = 2'd3
  } state_t;

  // Only FIXED and INCR bursts are served; anything else is answered with SLVERR.
  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_ram_bytemem.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module axi_ram_bytemem
  import axi4_pkg::*;
#(
  parameter int unsigned WORDS_W = 12
) (
  input  logic               clk_i,
  input  logic [WORDS_W-1:0] addr_i,
  input  logic [3:0]         we_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o
);

  logic [31:0] mem [2**WORDS_W];

  // Byte-masked write and read-before-write registered read of the same word.
  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/axi4_ram_responder.sv
// AXI4 responder backed by on-chip word RAM: one burst in flight, FIXED/INCR,
// SLVERR for out-of-range beats and unsupported burst types.
module axi4_ram_responder
  import axi4_pkg::*;
#(
  parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
  parameter int unsigned MEM_WORDS_W = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        axi_awvalid_i,
  output logic        axi_awready_o,
  input  logic [31:0] axi_awaddr_i,
  input  logic [3:0]  axi_awid_i,
  input  logic [7:0]  axi_awlen_i,
  input  logic [1:0]  axi_awburst_i,
  input  logic        axi_wvalid_i,
  output logic        axi_wready_o,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  input  logic        axi_wlast_i,
  output logic        axi_bvalid_o,
  input  logic        axi_bready_i,
  output logic [1:0]  axi_bresp_o,
  output logic [3:0]  axi_bid_o,
  input  logic        axi_arvalid_i,
  output logic        axi_arready_o,
  input  logic [31:0] axi_araddr_i,
  input  logic [3:0]  axi_arid_i,
  input  logic [7:0]  axi_arlen_i,
  input  logic [1:0]  axi_arburst_i,
  output logic        axi_rvalid_o,
  input  logic        axi_rready_i,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  output logic [3:0]  axi_rid_o,
  output logic        axi_rlast_o
);

  localparam logic [31:0] MEM_SPAN = 32'd4 << MEM_WORDS_W;

  state_t      state;
  logic        last_read;
  logic [31:0] addr;
  logic [7:0]  cnt;
  logic [1:0]  burst;
  logic [3:0]  id;
  logic        wr_err;
  logic [1:0]  bresp_q;

  logic        grant_read;
  logic        ar_hs;
  logic        aw_hs;
  logic [31:0] beat_off;
  logic        beat_ok;
  logic [31:0] next_addr;
  logic        wlast_bad;
  logic [31:0] ram_byte_addr;
  logic [31:0] ram_off;
  logic [3:0]  ram_we;
  logic [31:0] ram_q;
  logic        unused_ram_off_bits;

  // Round-robin arbiter: on a tie the direction not served last wins.
  always_comb begin
    grant_read    = axi_arvalid_i && (!axi_awvalid_i || !last_read);
    axi_arready_o = (state == IDLE) && grant_read;
    axi_awready_o = (state == IDLE) && axi_awvalid_i && !grant_read;
    ar_hs         = axi_arready_o;
    aw_hs         = axi_awready_o;
  end

  // Current beat legality, next beat address and wlast consistency.
  always_comb begin
    beat_off  = addr - MEM_BASE;
    beat_ok   = burst_supported(burst) && (beat_off < MEM_SPAN);
    next_addr = (burst == BURST_INCR) ? addr + 32'd4 : addr;
    wlast_bad = axi_wlast_i != (cnt == '0);
  end

  // RAM port steering: the address of the beat to be shown next cycle is
  // presented now, so read data is already valid when rvalid rises and
  // simply re-reads the same word while the master stalls.
  always_comb begin
    ram_byte_addr = addr;
    if (state == IDLE) begin
      ram_byte_addr = axi_araddr_i;
    end else if ((state == READ) && axi_rready_i) begin
      ram_byte_addr = next_addr;
    end
    ram_off             = ram_byte_addr - MEM_BASE;
    unused_ram_off_bits = ^{ram_off[31:MEM_WORDS_W+2], ram_off[1:0]};
    ram_we              = ((state == WRITE) && axi_wvalid_i && beat_ok) ? axi_wstrb_i : '0;
  end

  axi_ram_bytemem #(
    .WORDS_W (MEM_WORDS_W)
  ) u_ram (
    .clk_i   (clk_i),
    .addr_i  (ram_off[MEM_WORDS_W+1:2]),
    .we_i    (ram_we),
    .wdata_i (axi_wdata_i),
    .rdata_o (ram_q)
  );

  // Burst FSM: latch the command, walk the beats, collect write errors.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      last_read <= 1'b0;
      addr      <= '0;
      cnt       <= '0;
      burst     <= '0;
      id        <= '0;
      wr_err    <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            addr      <= axi_araddr_i;
            cnt       <= axi_arlen_i;
            burst     <= axi_arburst_i;
            id        <= axi_arid_i;
            last_read <= 1'b1;
            state     <= READ;
          end else if (aw_hs) begin
            addr      <= axi_awaddr_i;
            cnt       <= axi_awlen_i;
            burst     <= axi_awburst_i;
            id        <= axi_awid_i;
            wr_err    <= 1'b0;
            last_read <= 1'b0;
            state     <= WRITE;
          end
        end
        READ: begin
          if (axi_rready_i) begin
            if (cnt == '0) begin
              state <= IDLE;
            end else begin
              cnt  <= cnt - 8'd1;
              addr <= next_addr;
            end
          end
        end
        WRITE: begin
          if (axi_wvalid_i) begin
            if (cnt == '0) begin
              bresp_q <= (wr_err || !beat_ok || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              state   <= WRESP;
            end else begin
              wr_err <= wr_err || !beat_ok || wlast_bad;
              cnt    <= cnt - 8'd1;
              addr   <= next_addr;
            end
          end
        end
        WRESP: begin
          if (axi_bready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channel outputs decoded from the FSM state; all are zero in reset.
  always_comb begin
    axi_wready_o = (state == WRITE);
    axi_bvalid_o = (state == WRESP);
    axi_bresp_o  = bresp_q;
    axi_bid_o    = (state == WRESP) ? id : '0;
    axi_rvalid_o = (state == READ);
    axi_rdata_o  = ((state == READ) && beat_ok) ? ram_q : '0;
    axi_rresp_o  = ((state == READ) && !beat_ok) ? RESP_SLVERR : RESP_OKAY;
    axi_rid_o    = (state == READ) ? id : '0;
    axi_rlast_o  = (state == READ) && (cnt == '0);
  end

endmodule

// File: tb/tb_axi4_ram_responder.sv
// Self-checking bench for axi4_ram_responder: vector table, directed corner
// sequences and randomized bursts against a reference memory.
module tb_axi4_ram_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] TOP  = 32'h8000_4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 0, awready;
  logic [31:0] awaddr = '0;
  logic [3:0]  awid = '0;
  logic [7:0]  awlen = '0;
  logic [1:0]  awburst = '0;
  logic        wvalid = 0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 0;
  logic        bvalid, bready = 0;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid = 0, arready;
  logic [31:0] araddr = '0;
  logic [3:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic [1:0]  arburst = '0;
  logic        rvalid, rready = 0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [4096];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  axi4_ram_responder #(
    .MEM_BASE    (BASE),
    .MEM_WORDS_W (12)
  ) dut (
    .clk_i (clk), .rst_i (rst),
    .axi_awvalid_i (awvalid), .axi_awready_o (awready), .axi_awaddr_i (awaddr),
    .axi_awid_i (awid), .axi_awlen_i (awlen), .axi_awburst_i (awburst),
    .axi_wvalid_i (wvalid), .axi_wready_o (wready), .axi_wdata_i (wdata),
    .axi_wstrb_i (wstrb), .axi_wlast_i (wlast),
    .axi_bvalid_o (bvalid), .axi_bready_i (bready), .axi_bresp_o (bresp), .axi_bid_o (bid),
    .axi_arvalid_i (arvalid), .axi_arready_o (arready), .axi_araddr_i (araddr),
    .axi_arid_i (arid), .axi_arlen_i (arlen), .axi_arburst_i (arburst),
    .axi_rvalid_o (rvalid), .axi_rready_i (rready), .axi_rdata_o (rdata),
    .axi_rresp_o (rresp), .axi_rid_o (rid), .axi_rlast_o (rlast)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: address legality and beat address from plain arithmetic.
  function automatic bit m_ok(input logic [31:0] a, input logic [1:0] b);
    return (b == 2'b00 || b == 2'b01) && (a >= BASE) && (a < TOP);
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] s, input logic [1:0] b, input int i);
    return (b == 2'b01) ? s + 32'(4 * i) : s;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic ar_phase(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                          input logic [1:0] b, input int gap);
    int cyc = 0;
    repeat (gap) begin @(posedge clk); #1; end
    arvalid = 1; araddr = a; arlen = len; arid = id; arburst = b;
    @(negedge clk);
    while (!arready && cyc < 50) begin
      @(posedge clk); #1; @(negedge clk); cyc++;
    end
    chk("ar_handshake", arready, 1);
    chk("ar_aw_excl", awready, 0);
    @(posedge clk); #1;
    arvalid = 0;
  endtask

  task automatic aw_phase(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                          input logic [1:0] b, input int gap);
    int cyc = 0;
    repeat (gap) begin @(posedge clk); #1; end
    awvalid = 1; awaddr = a; awlen = len; awid = id; awburst = b;
    @(negedge clk);
    while (!awready && cyc < 50) begin
      @(posedge clk); #1; @(negedge clk); cyc++;
    end
    chk("aw_handshake", awready, 1);
    chk("aw_ar_excl", arready, 0);
    @(posedge clk); #1;
    awvalid = 0;
  endtask

  // Collect len+1 beats under random rready; every cycle with rvalid is
  // compared, so stalled beats must hold their values.
  task automatic read_data(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                           input logic [1:0] b, input int p_ready, input bit chk_lat);
    int beat = 0;
    int cyc = 0;
    logic [31:0] ba, ed;
    bit ok;
    while (beat <= int'(len) && cyc < 3000) begin
      rready = ($urandom_range(99) < p_ready);
      @(negedge clk);
      if (chk_lat && cyc == 0) chk("r_latency", rvalid, 1);
      if (rvalid) begin
        ba = m_addr(a, b, beat);
        ok = m_ok(ba, b);
        ed = ok ? mem_m[m_idx(ba)] : 32'h0;
        chk("r_data", rdata, ed);
        chk("r_resp", rresp, ok ? 2'b00 : 2'b10);
        chk("r_last", rlast, beat == int'(len));
        chk("r_id", rid, id);
        if (rready) beat++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    rready = 0;
    chk("r_beats", beat, int'(len) + 1);
    @(negedge clk);
    chk("r_end", rvalid, 0);
    @(posedge clk); #1;
  endtask

  // Drive len+1 beats from wd/ws under random wvalid, update the model, then
  // take the write response under random bready.
  task automatic write_data(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                            input logic [1:0] b, input int wlast_beat,
                            input int p_valid, input int p_bready);
    int beat = 0;
    int cyc = 0;
    bit err = 0;
    bit done = 0;
    logic [31:0] ba;
    while (beat <= int'(len) && cyc < 3000) begin
      wvalid = ($urandom_range(99) < p_valid);
      wdata = wd[beat]; wstrb = ws[beat]; wlast = (beat == wlast_beat);
      @(negedge clk);
      if (wvalid) begin
        chk("w_ready", wready, 1);
        if (wready) begin
          ba = m_addr(a, b, beat);
          if (m_ok(ba, b)) begin
            for (int k = 0; k < 4; k++)
              if (ws[beat][k]) mem_m[m_idx(ba)][k*8 +: 8] = wd[beat][k*8 +: 8];
          end else err = 1;
          if ((beat == wlast_beat) != (beat == int'(len))) err = 1;
          beat++;
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    wvalid = 0; wlast = 0;
    chk("w_beats", beat, int'(len) + 1);
    cyc = 0;
    while (!done && cyc < 200) begin
      bready = ($urandom_range(99) < p_bready);
      @(negedge clk);
      if (cyc == 0) chk("b_latency", bvalid, 1);
      if (bvalid) begin
        chk("b_resp", bresp, err ? 2'b10 : 2'b00);
        chk("b_id", bid, id);
        if (bready) done = 1;
      end
      cyc++;
      @(posedge clk); #1;
    end
    bready = 0;
    chk("b_done", done, 1);
  endtask

  task automatic single_read(input logic [31:0] a, input logic [1:0] b,
                             input logic [31:0] ed, input logic [1:0] er);
    ar_phase(a, 8'd0, 4'h5, b, 0);
    rready = 1;
    @(negedge clk);
    chk("sr_rvalid", rvalid, 1);
    chk("sr_rdata", rdata, ed);
    chk("sr_rresp", rresp, er);
    chk("sr_rlast", rlast, 1);
    @(posedge clk); #1;
    rready = 0;
    @(negedge clk);
    chk("sr_idle", rvalid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{32'h8000_0000, 2'b01, 32'd0,    2'b00};
    vecs[1] = '{32'h8000_0004, 2'b00, 32'd1,    2'b00};
    vecs[2] = '{32'h8000_3FFC, 2'b01, 32'd4095, 2'b00};
    vecs[3] = '{32'h8000_4000, 2'b01, 32'd0,    2'b10};
    vecs[4] = '{32'h7FFF_FFFC, 2'b01, 32'd0,    2'b10};
    vecs[5] = '{32'h8000_0020, 2'b10, 32'd0,    2'b10};
    vecs[6] = '{32'h8000_0022, 2'b01, 32'd8,    2'b00};
    vecs[7] = '{32'h8000_0010, 2'b11, 32'd0,    2'b10};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", awready, 0); chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);   chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);   chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);     chk("rst_bid", bid, 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // Preload word i with value i
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = 32'(k * 256 + i); ws[i] = 4'hF; end
      aw_phase(BASE + 32'(k * 1024), 8'd255, 4'h1, 2'b01, 0);
      write_data(BASE + 32'(k * 1024), 8'd255, 4'h1, 2'b01, 255, 100, 100);
    end

    // Vector table of single-beat reads
    for (int v = 0; v < 8; v++)
      single_read(vecs[v].addr, vecs[v].burst, vecs[v].exp_data, vecs[v].exp_resp);

    // INCR read of eight beats with first-beat latency check
    ar_phase(BASE, 8'd7, 4'h3, 2'b01, 0);
    read_data(BASE, 8'd7, 4'h3, 2'b01, 100, 1);

    // INCR write with a half-word strobe on beat 2, then readback
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0A0_A0A0 + 32'(i) * 32'h0101_0101; ws[i] = 4'hF; end
    ws[1] = 4'b0011;
    aw_phase(32'h8000_0010, 8'd3, 4'h9, 2'b01, 0);
    write_data(32'h8000_0010, 8'd3, 4'h9, 2'b01, 3, 100, 100);
    single_read(32'h8000_0014, 2'b01, 32'h0000_A1A1, 2'b00);
    single_read(32'h8000_0010, 2'b01, 32'hA0A0_A0A0, 2'b00);

    // Burst straddling the top of RAM
    ar_phase(TOP - 32'd8, 8'd3, 4'h2, 2'b01, 0);
    read_data(TOP - 32'd8, 8'd3, 4'h2, 2'b01, 100, 1);

    // WRAP write leaves RAM untouched and reports SLVERR
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    aw_phase(BASE + 32'h40, 8'd3, 4'h4, 2'b10, 0);
    write_data(BASE + 32'h40, 8'd3, 4'h4, 2'b10, 3, 100, 100);
    single_read(BASE + 32'h40, 2'b01, 32'd16, 2'b00);
    ar_phase(BASE + 32'h40, 8'd3, 4'h4, 2'b01, 0);
    read_data(BASE + 32'h40, 8'd3, 4'h4, 2'b01, 100, 0);

    // Early wlast: all four beats accepted, response SLVERR
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    aw_phase(BASE + 32'h80, 8'd3, 4'h6, 2'b01, 0);
    write_data(BASE + 32'h80, 8'd3, 4'h6, 2'b01, 1, 100, 100);
    ar_phase(BASE + 32'h80, 8'd3, 4'h6, 2'b01, 0);
    read_data(BASE + 32'h80, 8'd3, 4'h6, 2'b01, 100, 0);

    // Randomized bursts with backpressure against the reference memory
    for (int n = 0; n < 1000; n++) begin
      int sel, len, wlb, pr;
      logic [1:0] b;
      logic [31:0] a;
      logic [3:0] id;
      len = $urandom_range(0, 15);
      sel = $urandom_range(0, 15);
      b = (sel < 10) ? 2'b01 : (sel < 14) ? 2'b00 : (sel == 14) ? 2'b10 : 2'b11;
      sel = $urandom_range(0, 7);
      if (sel == 0) a = TOP - 32'(4 * $urandom_range(0, 8));
      else if (sel == 1) a = BASE - 32'(4 * $urandom_range(1, 4));
      else a = BASE + 32'(4 * $urandom_range(0, 4079));
      a[1:0] = 2'($urandom_range(0, 3));
      id = 4'($urandom);
      pr = $urandom_range(30, 100);
      if ($urandom_range(0, 1) == 0) begin
        ar_phase(a, 8'(len), id, b, $urandom_range(0, 2));
        read_data(a, 8'(len), id, b, pr, 1);
      end else begin
        for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        wlb = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 16) : len;
        aw_phase(a, 8'(len), id, b, $urandom_range(0, 2));
        write_data(a, 8'(len), id, b, wlb, pr, $urandom_range(30, 100));
      end
    end

    // Reset mid-read: rvalid must drop without a clock edge
    ar_phase(BASE, 8'd15, 4'hA, 2'b01, 0);
    rready = 1;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_rlast", rlast, 0);
    rready = 0;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // Simultaneous AR/AW: grants alternate starting with read after reset
    for (int r = 0; r < 4; r++) begin
      bit exp_rd;
      exp_rd = (r % 2 == 0);
      arvalid = 1; araddr = BASE + 32'h100; arlen = 0; arid = 4'h7; arburst = 2'b01;
      awvalid = 1; awaddr = BASE + 32'h200; awlen = 0; awid = 4'h8; awburst = 2'b01;
      @(negedge clk);
      chk("arb_arready", arready, exp_rd);
      chk("arb_awready", awready, !exp_rd);
      @(posedge clk); #1;
      arvalid = 0; awvalid = 0;
      if (exp_rd) read_data(BASE + 32'h100, 8'd0, 4'h7, 2'b01, 100, 1);
      else begin
        wd[0] = $urandom; ws[0] = 4'hF;
        write_data(BASE + 32'h200, 8'd0, 4'h8, 2'b01, 0, 100, 100);
      end
    end
    ar_phase(BASE + 32'h200, 8'd3, 4'hB, 2'b01, 0);
    read_data(BASE + 32'h200, 8'd3, 4'hB, 2'b01, 100, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_ram_responder.md
# axi4_ram_responder

AXI4 responder (slave) that terminates one instruction-side or data-side AXI master port of the core/cache cluster and backs it with on-chip word-addressed RAM. It accepts single-beat and burst reads and writes: 32-bit data, 4-bit IDs, 8-bit lengths, FIXED/INCR bursts. It completes every accepted burst with a protocol-correct response, including error bursts. Used as the memory model in core-level benches and as tightly-coupled RAM in FPGA builds.

## Interface
Parameters:
- MEM_BASE, 32'h80000000, byte address of word 0
- MEM_WORDS_W, 12, log2 of RAM depth in 32-bit words (default 16 KiB)

Ports:
- clk_i  in  1  clock, all logic rising-edge
- rst_i  in  1  reset, asynchronous, active-high
- axi_awvalid_i / axi_awready_o  in/out  1  write-address handshake
- axi_awaddr_i  in  32  burst start byte address
- axi_awid_i  in  4  write ID
- axi_awlen_i  in  8  beats minus one
- axi_awburst_i  in  2  burst type
- axi_wvalid_i / axi_wready_o  in/out  1  write-data handshake
- axi_wdata_i  in  32  write data
- axi_wstrb_i  in  4  byte enables
- axi_wlast_i  in  1  last write beat
- axi_bvalid_o / axi_bready_i  out/in  1  write-response handshake
- axi_bresp_o  out  2  write response
- axi_bid_o  out  4  echoed awid
- axi_arvalid_i / axi_arready_o  in/out  1  read-address handshake
- axi_araddr_i  in  32  burst start byte address
- axi_arid_i  in  4  read ID
- axi_arlen_i  in  8  beats minus one
- axi_arburst_i  in  2  burst type
- axi_rvalid_o / axi_rready_i  out/in  1  read-data handshake
- axi_rdata_o  out  32  read data
- axi_rresp_o  out  2  per-beat response
- axi_rid_o  out  4  echoed arid
- axi_rlast_o  out  1  last read beat

## Operation
- FSM states: IDLE, WRITE, WRESP, READ. One burst in flight; no read/write overlap.
- IDLE: awready/arready combinational, high only in IDLE, never both in one cycle. When arvalid and awvalid are both high, grant round-robin against the last-served direction. After reset, read wins first.
- AR handshake: latch arid, address, beat count = arlen, burst type; go to READ.
- AW handshake: latch the same from the AW channel; go to WRITE.
- Beat address:
  - FIXED (2'b00): constant.
  - INCR (2'b01): +4 per beat, 32-bit modular add.
  - addr[1:0] is ignored (word-aligned access).
- Beat is OK when burst type is 00/01 and the address lies in [MEM_BASE, MEM_BASE + 4*2^MEM_WORDS_W). Otherwise the beat is SLVERR (2'b10).
- WRAP/reserved bursts: SLVERR on every beat; the full awlen+1 / arlen+1 beats still complete.
- READ:
  - rvalid stays high for arlen+1 beats.
  - rresp is set per beat; rdata = 0 on SLVERR beats.
  - rlast is high on the final beat.
  - Returns to IDLE after the final handshake.
- WRITE:
  - wready high; each W handshake writes the strobed bytes of OK beats only.
  - Burst ends on beat awlen+1 regardless of wlast.
  - bresp = SLVERR if any beat was SLVERR or wlast disagreed with the beat count on any beat; otherwise OKAY.
  - Go to WRESP.
- WRESP: bvalid held until bready, with bid = latched awid; then IDLE.
- RAM contents are not reset.

## Timing
- All outputs reset to 0; the FSM resets to IDLE.
- Reset mid-burst aborts the burst immediately; no response is issued for it.
- Read latency: first rvalid in the cycle after the AR handshake. Beats are back-to-back while rready is high.
- The RAM is synchronous-read. The next beat's address is presented on the handshake cycle, so rdata is valid whenever rvalid is high.
- rvalid, rdata, rresp and rlast stay stable while rvalid && !rready.
- Write throughput: one beat per cycle. bvalid rises in the cycle after the final W handshake.
- Turnaround: IDLE for at least one cycle between bursts. The next AR/AW is accepted in the cycle after the final R or B handshake.
- Max burst is 256 beats; the beat counter is 8 bits and counts down to 0.

## Structure
- Package axi4_pkg holds:
  - burst encodings: FIXED 2'b00, INCR 2'b01, WRAP 2'b10
  - response codes: OKAY 2'b00, SLVERR 2'b10
  - FSM state enum
- Sub-module axi_ram_bytemem: single-port 2^MEM_WORDS_W x 32 RAM with 4-bit byte write enable and registered read. The top holds the FSM, counters, address generator and arbiter.

## Test plan
- INCR read, araddr 0x80000000, arlen 7, arid 3, RAM preloaded with word index -> eight beats with rdata 0..7, rid 3, rresp 0, rlast only on beat 8, first rvalid 1 cycle after the AR handshake.
- INCR write, awaddr 0x80000010, awlen 3, wstrb 4'b0011 on beat 2, then readback -> only the low half-word of 0x80000014 changes; bresp 0, bid echoed.
- Random rready/bready/wvalid/arvalid backpressure over 1000 bursts -> outputs stable under stall; scoreboard matches a reference memory.
- arvalid and awvalid high in the same cycle, repeated 4 times -> grants alternate read, write, read, write; never both ready.
- Burst straddling the top (araddr MEM_BASE+4*2^MEM_WORDS_W-8, arlen 3) -> beats 1-2 OKAY, beats 3-4 SLVERR with rdata 0; a WRAP write of 4 beats -> no RAM change, bresp 2'b10.
- wlast asserted on beat 2 of awlen 3 -> 4 beats accepted, bresp SLVERR. rst_i pulsed mid-read -> rvalid drops asynchronously, the next AR is served normally.
